// File: rtl/liquid_glitch_anim.sv
// liquid_glitch_anim: pipelined per-channel mask-and-shift glitch with frame-latched, optionally animated level
//   clk, rst_n (async active-low) ; vid_p*_in pixel/DE/HSync/VSync in ; level, anim_en, anim_rate controls
//   vid_p*_out processed pixel and syncs (2 clk latency) ; level_active = level currently applied
//   LIQUID_GLITCH_WRAP_EN: rotate each channel left by L instead of mask-and-shift
module liquid_glitch_anim #(
  parameter int CH_W   = 8,
  parameter int NUM_CH = 3,
  parameter int LVL_W  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CH*CH_W-1:0] vid_pData_in,
  input  logic                   vid_pVDE_in,
  input  logic                   vid_pHSync_in,
  input  logic                   vid_pVSync_in,
  input  logic [LVL_W-1:0]       level,
  input  logic                   anim_en,
  input  logic [7:0]             anim_rate,
  output logic [NUM_CH*CH_W-1:0] vid_pData_out,
  output logic                   vid_pVDE_out,
  output logic                   vid_pHSync_out,
  output logic                   vid_pVSync_out,
  output logic [LVL_W-1:0]       level_active
);
  localparam int PW = NUM_CH * CH_W;
  typedef enum logic [1:0] {STATIC, RAMP_UP, RAMP_DOWN} state_t;
  state_t state, state_n;
  logic [LVL_W-1:0] lvl_n, lc, l1;
  logic [7:0] cnt, cnt_n, rate;
  logic vs_q, fb, de1, hs1, vs1, go_up;
  logic [PW-1:0] d1, sh;
  logic [CH_W-1:0] ch;
  assign lc   = (level > LVL_W'(CH_W - 1)) ? LVL_W'(CH_W - 1) : level;
  assign rate = (anim_rate == 8'd0) ? 8'd1 : anim_rate;
  assign fb   = vid_pVSync_in & ~vs_q;
  // a step heads up while below the clamped peak (or bouncing off 0), otherwise down
  assign go_up = (state == RAMP_UP) ? (level_active < lc) : (level_active == '0);
  always_comb begin
    state_n = state;
    lvl_n   = level_active;
    cnt_n   = cnt;
    if (fb) begin
      if (!anim_en) begin
        state_n = STATIC;
        lvl_n   = lc;
        cnt_n   = '0;
      end else if (state == STATIC) begin
        state_n = (level_active <= lc) ? RAMP_UP : RAMP_DOWN;
        cnt_n   = '0;
      end else if ({1'b0, cnt} + 9'd1 < {1'b0, rate}) begin
        cnt_n = cnt + 8'd1;
      end else begin
        cnt_n   = '0;
        state_n = go_up ? RAMP_UP : RAMP_DOWN;
        lvl_n   = go_up ? ((level_active < lc) ? level_active + LVL_W'(1) : level_active)
                        : ((level_active != '0) ? level_active - LVL_W'(1) : level_active);
      end
    end
  end
  // truncating left shift drops exactly the top L bits, i.e. the mask-then-shift result
  always_comb begin
    sh = '0;
    ch = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch = d1[i*CH_W +: CH_W];
`ifdef LIQUID_GLITCH_WRAP_EN
      sh[i*CH_W +: CH_W] = CH_W'(({ch, ch} << l1) >> CH_W);
`else
      sh[i*CH_W +: CH_W] = ch << l1;
`endif
    end
  end
  // the stage-1 level takes the next-state value so the FB-cycle pixel already uses the new L
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= STATIC;
      level_active   <= '0;
      cnt            <= '0;
      vs_q           <= 1'b0;
      d1             <= '0;
      de1            <= 1'b0;
      hs1            <= 1'b0;
      vs1            <= 1'b0;
      l1             <= '0;
      vid_pData_out  <= '0;
      vid_pVDE_out   <= 1'b0;
      vid_pHSync_out <= 1'b0;
      vid_pVSync_out <= 1'b0;
    end else begin
      state          <= state_n;
      level_active   <= lvl_n;
      cnt            <= cnt_n;
      vs_q           <= vid_pVSync_in;
      d1             <= vid_pData_in;
      de1            <= vid_pVDE_in;
      hs1            <= vid_pHSync_in;
      vs1            <= vid_pVSync_in;
      l1             <= lvl_n;
      vid_pData_out  <= sh;
      vid_pVDE_out   <= de1;
      vid_pHSync_out <= hs1;
      vid_pVSync_out <= vs1;
    end
  end
endmodule

// File: tb/tb_liquid_glitch_anim.sv
// tb_liquid_glitch_anim: scoreboard bench for liquid_glitch_anim with directed pixels and level sweeps
module tb_liquid_glitch_anim;
`ifdef LIQUID_GLITCH_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [23:0] data_in = '0;
  logic de_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
  logic [2:0] level = '0;
  logic anim_en = 1'b0;
  logic [7:0] anim_rate = '0;
  logic [23:0] data_out;
  logic de_out, hs_out, vs_out;
  logic [2:0] level_active;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  typedef struct {
    logic [23:0] d;
    logic hs;
    logic vs;
    int t;
  } exp_t;
  exp_t q[$];
  liquid_glitch_anim dut (
    .clk(clk), .rst_n(rst_n),
    .vid_pData_in(data_in), .vid_pVDE_in(de_in), .vid_pHSync_in(hs_in), .vid_pVSync_in(vs_in),
    .level(level), .anim_en(anim_en), .anim_rate(anim_rate),
    .vid_pData_out(data_out), .vid_pVDE_out(de_out), .vid_pHSync_out(hs_out), .vid_pVSync_out(vs_out),
    .level_active(level_active)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", n, a, e);
    end
  endtask
  task automatic px(input logic [23:0] d, input logic de, input logic hs, input logic vs,
                    input logic [23:0] et, input logic [23:0] ew);
    exp_t x;
    data_in = d;
    de_in = de;
    hs_in = hs;
    vs_in = vs;
    if (de) begin
      x.d = WRAP ? ew : et;
      x.hs = hs;
      x.vs = vs;
      x.t = cyc;
      q.push_back(x);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic fb_cycle();
    px(24'h0, 1'b0, 1'b0, 1'b1, 24'h0, 24'h0);
    px(24'h0, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
  endtask
  always @(negedge clk) begin
    if (rst_n && de_out) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pixel got=%0h expected=none", data_out);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("pix_data", data_out, x.d);
        chk("pix_hsync", hs_out, x.hs);
        chk("pix_vsync", vs_out, x.vs);
        chk("pix_latency", cyc - x.t, 2);
      end
    end
  end
  int seq[15] = '{0, 0, 1, 1, 2, 2, 3, 3, 2, 2, 1, 1, 0, 0, 1};
  logic [23:0] pexp[4] = '{24'h010101, 24'h020202, 24'h040404, 24'h080808};
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", data_out, 0);
    chk("rst_de", de_out, 0);
    chk("rst_hs", hs_out, 0);
    chk("rst_vs", vs_out, 0);
    chk("rst_level", level_active, 0);
    rst_n = 1'b1;
    level = 3'd1;
    px(24'hFF8040, 1'b1, 1'b0, 1'b0, 24'hFF8040, 24'hFF8040);
    px(24'h0, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
    px(24'h0, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
    chk("level_before_fb", level_active, 0);
    px(24'hFF8040, 1'b1, 1'b0, 1'b1, 24'hFE0080, 24'hFF0180);
    chk("level_at_fb", level_active, 1);
    px(24'hFF8040, 1'b1, 1'b1, 1'b1, 24'hFE0080, 24'hFF0180);
    px(24'h0, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
    level = 3'd7;
    px(24'h010203, 1'b1, 1'b0, 1'b0, 24'h020406, 24'h020406);
    chk("level_no_tear", level_active, 1);
    fb_cycle();
    chk("level_7", level_active, 7);
    px(24'h010203, 1'b1, 1'b0, 1'b0, 24'h800080, 24'h800181);
    level = 3'd1;
    fb_cycle();
    level = 3'd3;
    px(24'h1F1F1F, 1'b1, 1'b0, 1'b0, 24'h3E3E3E, 24'h3E3E3E);
    chk("level_mid_frame", level_active, 1);
    fb_cycle();
    chk("level_3", level_active, 3);
    px(24'h1F1F1F, 1'b1, 1'b1, 1'b0, 24'hF8F8F8, 24'hF8F8F8);
    px(24'hE0E0E0, 1'b1, 1'b0, 1'b0, 24'h000000, 24'h070707);
    data_in = 24'h1F1F1F;
    de_in = 1'b0;
    @(posedge clk);
    #1;
    data_in = 24'h0;
    @(posedge clk);
    #1;
    chk("blank_data", data_out, 24'hF8F8F8);
    chk("blank_de", de_out, 0);
    anim_en = 1'b0;
    level = 3'd0;
    fb_cycle();
    chk("anim_start", level_active, 0);
    anim_en = 1'b1;
    level = 3'd3;
    anim_rate = 8'd2;
    for (int k = 0; k < 15; k++) begin
      px(24'h0, 1'b0, 1'b0, 1'b1, 24'h0, 24'h0);
      chk("anim_level", level_active, seq[k]);
      px(24'h010101, 1'b1, 1'b0, 1'b1, pexp[seq[k]], pexp[seq[k]]);
      repeat (3) px(24'h0, 1'b0, 1'b1, 1'b1, 24'h0, 24'h0);
      chk("anim_hold", level_active, seq[k]);
      px(24'h0, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
      px(24'h0, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
    end
    anim_en = 1'b0;
    px(24'h010101, 1'b1, 1'b0, 1'b0, 24'h020202, 24'h020202);
    px(24'h010101, 1'b1, 1'b0, 1'b0, 24'h020202, 24'h020202);
    data_in = 24'hFF8040;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", data_out, 0);
    chk("mid_rst_de", de_out, 0);
    chk("mid_rst_level", level_active, 0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    px(24'hFF8040, 1'b1, 1'b0, 1'b0, 24'hFF8040, 24'hFF8040);
    chk("post_rst_level", level_active, 0);
    px(24'h0, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
